cpu_run_monitor: RTL and testbench
==================================

# cpu_run_monitor

Parametrised run-control companion for the pipelined CPU in the simulation harness. The clock-only bench just free-runs the CPU; this block also:
- watches the fetch stage for the halt word;
- counts cycles and fetched instructions;
- lets the pipeline drain for a fixed number of non-stalled cycles;
- sequences a word-by-word data-memory dump with a valid/ready handshake;
- flags a watchdog timeout if no halt arrives.

It sits beside `CPU` in the harness, fed from IF-stage taps, and drives the dump port of the memory reader.

## Interface
Parameters:
- DATA_W, 32, instruction width
- ADDR_W, 32, dump word-address width
- CNT_W, 32, width of both counters
- HALT_WORD, 32'hFFFF_FFFF, instruction value that ends the run
- DRAIN_CYCLES, 5, non-stalled cycles to wait after halt (0 allowed)
- DUMP_WORDS, 512, words to dump (≥1, ≤ 2^ADDR_W)
- TIMEOUT, 100000, cycle limit for RUN+DRAIN (≥1, < 2^CNT_W)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- fetch_valid  in  1  IF stage holds a real instruction
- fetch_instr  in  DATA_W  IF-stage instruction
- stall  in  1  pipeline stall (IF not advancing)
- dump_ready  in  1  memory reader accepts dump_addr
- cycle_count  out  CNT_W  cycles spent in RUN+DRAIN
- instr_count  out  CNT_W  non-halt instructions accepted in RUN
- dump_valid  out  1  dump_addr is valid
- dump_addr  out  ADDR_W  word address being dumped
- dump_last  out  1  current dump_addr is DUMP_WORDS-1
- done  out  1  run finished and dump completed (sticky)
- timeout  out  1  watchdog fired (sticky)

## Operation
- States: RUN, DRAIN, DUMP, DONE, FAULT. Reset state is RUN.
- **Accept.** An instruction is "accepted" in a cycle with fetch_valid=1 and stall=0.
- **RUN**
  - cycle_count += 1 every cycle.
  - An accepted instruction ≠ HALT_WORD increments instr_count.
  - An accepted HALT_WORD moves to DRAIN, loading drain_cnt=DRAIN_CYCLES. If DRAIN_CYCLES=0 it goes directly to DUMP. The halt is not counted in instr_count.
  - A HALT_WORD with stall=1 or fetch_valid=0 is ignored.
- **DRAIN**
  - cycle_count += 1 every cycle.
  - drain_cnt decrements only on cycles with stall=0.
  - In the cycle drain_cnt reaches 0, the next state is DUMP.
  - fetch inputs are ignored.
- **Watchdog**
  - In RUN or DRAIN, when the increment makes cycle_count == TIMEOUT, go to FAULT.
  - Halt acceptance and watchdog in the same cycle: halt wins (DRAIN, or DUMP if DRAIN_CYCLES=0). The watchdog stays armed in DRAIN.
- **DUMP**
  - dump_valid=1; dump_addr starts at 0.
  - On dump_valid && dump_ready, dump_addr += 1.
  - While dump_ready=0, dump_addr and dump_last hold.
  - dump_last = (dump_addr == DUMP_WORDS-1).
  - A handshake with dump_last=1 moves to DONE.
- **DONE:** done=1, dump_valid=0, dump_addr holds the last value. Sticky until RESET.
- **FAULT:** timeout=1, done=0, dump_valid=0, no dump. Sticky until RESET.
- **Counters**
  - Both counters freeze outside RUN/DRAIN.
  - Both saturate at 2^CNT_W-1; no wrap.
  - instr_count ≤ cycle_count always.
- **Reset**
  - RESET asserted at any time (including mid-DRAIN or mid-DUMP) immediately clears all outputs to 0 and returns to RUN.
  - A dump in progress is abandoned; there is no partial-dump flag.

## Timing
- All outputs are registered. Reset values: every output 0.
- cycle_count reads 1 after the first rising edge with RESET low.
- Halt accepted at edge k:
  - state=DRAIN after edge k;
  - with no stalls, dump_valid=1 after edge k+DRAIN_CYCLES;
  - with DRAIN_CYCLES=0, dump_valid=1 after edge k.
- Each stalled DRAIN cycle delays dump_valid by exactly one cycle.
- Dump with dump_ready held at 1:
  - one address per cycle;
  - done=1 one cycle after the dump_last handshake;
  - total DUMP time is DUMP_WORDS cycles.
- timeout rises after the edge where cycle_count becomes TIMEOUT. cycle_count then reads TIMEOUT permanently.

## Test plan
1. **Reset.** Assert RESET mid-cycle with all inputs at 0 → all outputs 0 asynchronously, before the next edge.
2. **Normal run.** DRAIN_CYCLES=5, DUMP_WORDS=4, dump_ready=1. Feed 10 accepted non-halt instructions, then HALT_WORD → instr_count=10; dump_valid rises 5 cycles after the halt edge; dump_addr 0,1,2,3; dump_last high only at 3; done=1 next cycle; counters frozen.
3. **Backpressure.** Toggle dump_ready 1,0,0,1,1,0,1 → dump_addr advances only on ready cycles, holds otherwise; exactly 4 handshakes before done.
4. **Stalls.**
   - HALT_WORD presented with stall=1 → ignored, still RUN.
   - Then accept halt and stall 3 of the DRAIN cycles → dump_valid rises 8 cycles after the halt edge.
5. **Watchdog.**
   - TIMEOUT=50, no halt → timeout=1 after edge 50; cycle_count=50 frozen; dump_valid never 1; done=0.
   - Halt accepted on cycle 50 → DRAIN, timeout=0.
6. **Reset mid-dump.** Assert RESET at dump_addr=2 → dump_valid=0 and counters 0 immediately. After release, the run restarts from RUN with cycle_count=1 after the first edge.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Run-control companion for the harness CPU: halt detection, cycle/instruction
// counting, pipeline drain, word-by-word data-memory dump and a run watchdog.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RUN   | CPU free-running; counting cycles and accepted instructions
// S_DRAIN | halt seen; waiting DRAIN_CYCLES non-stalled cycles
// S_DUMP  | presenting dump_addr with dump_valid until last handshake
// S_DONE  | dump complete; done sticky until RESET
// S_FAULT | watchdog expired; timeout sticky until RESET
module cpu_run_monitor #(
    parameter int                   DATA_W       = 32,
    parameter int                   ADDR_W       = 32,
    parameter int                   CNT_W        = 32,
    parameter logic [DATA_W-1:0]    HALT_WORD    = 32'hFFFF_FFFF,
    parameter int                   DRAIN_CYCLES = 5,
    parameter longint unsigned      DUMP_WORDS   = 512,
    parameter longint unsigned      TIMEOUT      = 100000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              fetch_valid,
    input  logic [DATA_W-1:0] fetch_instr,
    input  logic              stall,
    input  logic              dump_ready,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done,
    output logic              timeout
);

    localparam int               DRN_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LD  = DRN_W'(DRAIN_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [CNT_W-1:0]  TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              dv_q, dv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              to_q, to_d;

    logic              accept;
    logic              halt_seen;
    logic [CNT_W-1:0]  cycle_inc;
    logic [CNT_W-1:0]  instr_inc;
    logic [ADDR_W-1:0] addr_next;

    assign accept    = fetch_valid & ~stall;
    assign halt_seen = accept && (fetch_instr == HALT_WORD);
    assign cycle_inc = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
    assign instr_inc = (instr_q == CNT_MAX) ? instr_q : instr_q + CNT_W'(1);
    assign addr_next = addr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        instr_d = instr_q;
        drain_d = drain_q;
        dv_d    = dv_q;
        addr_d  = addr_q;
        last_d  = last_q;
        done_d  = done_q;
        to_d    = to_q;

        case (state_q)
            S_RUN: begin
                cycle_d = cycle_inc;
                if (accept && !halt_seen) begin
                    instr_d = instr_inc;
                end
                // A halt in the same cycle as the watchdog expiry still ends the run normally.
                if (halt_seen) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_DUMP;
                        dv_d    = 1'b1;
                        addr_d  = '0;
                        last_d  = (LAST_ADDR == '0);
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LD;
                    end
                end else if (cycle_inc == TO_VAL) begin
                    state_d = S_FAULT;
                    to_d    = 1'b1;
                end
            end

            S_DRAIN: begin
                cycle_d = cycle_inc;
                if (!stall && (drain_q == DRN_W'(1))) begin
                    state_d = S_DUMP;
                    drain_d = '0;
                    dv_d    = 1'b1;
                    addr_d  = '0;
                    last_d  = (LAST_ADDR == '0);
                end else begin
                    if (!stall) begin
                        drain_d = drain_q - DRN_W'(1);
                    end
                    if (cycle_inc == TO_VAL) begin
                        state_d = S_FAULT;
                        to_d    = 1'b1;
                    end
                end
            end

            S_DUMP: begin
                if (dump_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                        dv_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_next;
                        last_d = (addr_next == LAST_ADDR);
                    end
                end
            end

            S_DONE, S_FAULT: begin
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_RUN;
            cycle_q <= '0;
            instr_q <= '0;
            drain_q <= '0;
            dv_q    <= 1'b0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
            drain_q <= drain_d;
            dv_q    <= dv_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign dump_valid  = dv_q;
    assign dump_addr   = addr_q;
    assign dump_last   = last_q;
    assign done        = done_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: a behavioural run model predicts every
// post-edge output snapshot and every dump handshake address.
module tb_cpu_run_monitor;

    localparam int          DRAIN = 5;
    localparam int          DUMPW = 4;
    localparam int          TO    = 50;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic        stall = 1'b0;
    logic        dump_ready = 1'b0;
    logic [31:0] cycle_count, instr_count, dump_addr;
    logic        dump_valid, dump_last, done, timeout;

    always #5 CLK = ~CLK;

    cpu_run_monitor #(
        .DATA_W(32), .ADDR_W(32), .CNT_W(32), .HALT_WORD(HALT),
        .DRAIN_CYCLES(DRAIN), .DUMP_WORDS(DUMPW), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .stall(stall), .dump_ready(dump_ready),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_last(dump_last),
        .done(done), .timeout(timeout)
    );

    typedef struct packed {
        logic [31:0] cc;
        logic [31:0] ic;
        logic        dv;
        logic [31:0] da;
        logic        dl;
        logic        dn;
        logic        to;
    } snap_t;

    int checks = 0;
    int errors = 0;
    snap_t       exp_q[$];
    logic [31:0] hs_q[$];

    // Reference run: phase flags plus counts, advanced once per clock edge.
    longint unsigned m_cycles, m_instrs;
    int  m_drain_left, m_idx;
    bit  m_halted, m_dumping, m_finished, m_faulted;

    function automatic void model_reset();
        m_cycles = 0; m_instrs = 0; m_drain_left = 0; m_idx = 0;
        m_halted = 0; m_dumping = 0; m_finished = 0; m_faulted = 0;
    endfunction

    function automatic void model_step(bit fv, logic [31:0] instr, bit st, bit rdy);
        if (m_finished || m_faulted) return;
        if (m_dumping) begin
            if (rdy) begin
                if (m_idx == DUMPW - 1) m_finished = 1;
                else m_idx++;
            end
            return;
        end
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        if (!m_halted) begin
            if (fv && !st) begin
                if (instr == HALT) begin
                    m_halted = 1;
                    m_drain_left = DRAIN;
                    if (DRAIN == 0) m_dumping = 1;
                    return;
                end
                m_instrs++;
            end
        end else if (!st) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_dumping = 1;
                return;
            end
        end
        if (m_cycles == TO) m_faulted = 1;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.cc = 32'(m_cycles);
        s.ic = 32'(m_instrs);
        s.dv = m_dumping && !m_finished;
        s.da = 32'(m_idx);
        s.dl = m_dumping && (m_idx == DUMPW - 1);
        s.dn = m_finished;
        s.to = m_faulted;
        return s;
    endfunction

    task automatic drive(bit fv, logic [31:0] instr, bit st, bit rdy);
        @(negedge CLK);
        fetch_valid = fv;
        fetch_instr = instr;
        stall       = st;
        dump_ready  = rdy;
        if (m_dumping && !m_finished && !m_faulted && rdy) hs_q.push_back(32'(m_idx));
        model_step(fv, instr, st, rdy);
        exp_q.push_back(model_snap());
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        fetch_valid = 1'b0; fetch_instr = '0; stall = 1'b0; dump_ready = 1'b0;
        #1;
        checks++;
        if ({cycle_count, instr_count, dump_valid, dump_addr, dump_last, done, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_clear: got cc=%0d ic=%0d dv=%0b da=%0d dl=%0b dn=%0b to=%0b expected all 0",
                     cycle_count, instr_count, dump_valid, dump_addr, dump_last, done, timeout);
        end
        checks++;
        if (hs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_at_reset: got hs=%0d snaps=%0d expected 0 0", hs_q.size(), exp_q.size());
        end
        hs_q.delete();
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge CLK);
        #3;
        RESET = 1'b0;
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    // Per-edge snapshot monitor.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{cycle_count, instr_count, dump_valid, dump_addr, dump_last, done, timeout};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL snap t=%0t: got cc=%0d ic=%0d dv=%0b da=%0d dl=%0b dn=%0b to=%0b expected cc=%0d ic=%0d dv=%0b da=%0d dl=%0b dn=%0b to=%0b",
                             $time, a.cc, a.ic, a.dv, a.da, a.dl, a.dn, a.to,
                             e.cc, e.ic, e.dv, e.da, e.dl, e.dn, e.to);
                end
            end
        end
    end

    // Dump handshake monitor.
    initial begin
        logic [31:0] ea;
        forever begin
            @(negedge CLK);
            #1;
            if (!RESET && dump_valid && dump_ready) begin
                checks++;
                if (hs_q.size() == 0) begin
                    errors++;
                    $display("FAIL handshake: got addr %0d expected no handshake", dump_addr);
                end else begin
                    ea = hs_q.pop_front();
                    if (dump_addr !== ea) begin
                        errors++;
                        $display("FAIL handshake: got addr %0d expected %0d", dump_addr, ea);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        model_reset();
        do_reset();

        // Normal run.
        repeat (10) begin
            ins = $urandom();
            if (ins == HALT) ins = 32'h0;
            drive(1, ins, 0, 1);
        end
        drive(1, HALT, 0, 0);
        for (int i = 1; i <= DRAIN; i++) begin
            drive(0, '0, 0, 0);
            settle();
            check_val("drain_wait_dv", 32'(dump_valid), 32'(i == DRAIN));
        end
        repeat (4) drive(0, '0, 0, 1);
        settle();
        check_val("normal_done", 32'(done), 1);
        check_val("normal_instr", instr_count, 10);
        check_val("normal_addr", dump_addr, 3);
        repeat (3) drive(1, 32'h5, 0, 1);
        settle();
        check_val("normal_frozen_cc", cycle_count, 16);

        // Backpressure.
        do_reset();
        drive(1, HALT, 0, 0);
        repeat (DRAIN) drive(0, '0, 0, 0);
        begin
            bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++) drive(0, '0, 0, pat[i]);
        end
        settle();
        check_val("bp_done", 32'(done), 1);

        // Stalls: stalled halt ignored, stalled drain cycles stretch the wait.
        do_reset();
        drive(1, HALT, 1, 0);
        drive(1, 32'h1234, 0, 0);
        drive(1, HALT, 0, 0);
        begin
            bit sp[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
            for (int i = 0; i < 8; i++) begin
                drive(1, 32'h77, sp[i], 0);
                settle();
                check_val("stall_drain_dv", 32'(dump_valid), 32'(i == 7));
            end
        end
        check_val("stall_instr", instr_count, 1);

        // Watchdog.
        do_reset();
        repeat (TO) drive(0, '0, 0, 1);
        settle();
        check_val("wd_timeout", 32'(timeout), 1);
        check_val("wd_cc", cycle_count, TO);
        repeat (5) drive(1, 32'h9, 0, 1);
        settle();
        check_val("wd_cc_frozen", cycle_count, TO);
        check_val("wd_no_dump", 32'(dump_valid), 0);
        check_val("wd_no_done", 32'(done), 0);

        // Halt on the watchdog cycle.
        do_reset();
        repeat (TO - 1) drive(0, '0, 0, 0);
        drive(1, HALT, 0, 0);
        settle();
        check_val("wd_halt_to", 32'(timeout), 0);
        check_val("wd_halt_cc", cycle_count, TO);
        repeat (DRAIN + 4) drive(0, '0, 0, 1);
        settle();
        check_val("wd_halt_done", 32'(done), 1);

        // Reset mid-dump.
        do_reset();
        drive(1, HALT, 0, 1);
        repeat (DRAIN) drive(0, '0, 0, 1);
        repeat (2) drive(0, '0, 0, 1);
        do_reset();
        drive(0, '0, 0, 0);
        settle();
        check_val("restart_cc", cycle_count, 1);

        // Randomised runs.
        for (int r = 0; r < 15; r++) begin
            do_reset();
            for (int c = 0; c < 100; c++) begin
                ins = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
                drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1);
            end
        end

        settle();
        #2;
        checks++;
        if (exp_q.size() != 0 || hs_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queues: got snaps=%0d hs=%0d expected 0 0", exp_q.size(), hs_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
